modn_updown_counter: RTL and testbench
======================================

Name: modn_updown_counter

Overview:
Parametrised modulo-N synchronous counter: the general-purpose successor to the fixed mod-8 up counter.
- Counts up or down through 0..MODULUS-1 with count enable and synchronous parallel load.
- Selectable wrap or saturate behaviour at the range ends; sticky overflow flag.
- Terminal-count output allows cascading into multi-digit counters (e.g. BCD timers, event counters).

Parameters:
WIDTH, 4, bit width of count and load value; must satisfy MODULUS <= 2**WIDTH
MODULUS, 10, number of count states (0..MODULUS-1); must be >= 2

Ports:
clk  input  1  clock, all state updates on rising edge
clr  input  1  asynchronous active-low reset; clears q and ovf immediately
en  input  1  count enable; counting only when 1
up  input  1  direction: 1 = increment, 0 = decrement
load  input  1  synchronous parallel load, overrides en
din  input  WIDTH  load value
sat  input  1  end-of-range mode: 1 = saturate, 0 = wrap
q  output  WIDTH  current count, registered
tc  output  1  terminal count, combinational: en & ((up & q==MODULUS-1) | (!up & q==0))
ovf  output  1  sticky overflow/underflow flag, registered

Behaviour:
- Reset: clr=0 asynchronously forces q=0 and ovf=0, independent of clk. Reset is released synchronously to the design by the environment. While clr=0, all other inputs are ignored.
- Priority on each rising edge with clr=1: load > en > hold.
- Load (load=1):
  - q <= din if din < MODULUS, else q <= MODULUS-1 (clamp).
  - ovf <= 0.
  - en, up and sat are ignored that cycle.
- Count (load=0, en=1):
  - up=1, q < MODULUS-1: q <= q+1.
  - up=1, q == MODULUS-1: q <= 0 if sat=0, else q holds MODULUS-1. ovf <= 1 in both cases.
  - up=0, q > 0: q <= q-1.
  - up=0, q == 0: q <= MODULUS-1 if sat=0, else q holds 0. ovf <= 1 in both cases.
- Hold (load=0, en=0): q and ovf unchanged.
- ovf:
  - Set on any edge where tc=1 and load=0.
  - Cleared only by clr or load.
  - Stays 1 across further counting.
- tc:
  - Purely combinational from en, up and registered q; zero latency.
  - Intended to drive the en of the next cascaded stage.
  - tc=0 whenever en=0.
- Latency: q reflects a count or load one clock after the qualifying edge inputs. There is no pipeline.
- Direction and sat may change on any cycle; the new value takes effect on the same edge.
- Arithmetic:
  - Increment/decrement in WIDTH bits; comparisons are against MODULUS-1 and 0 only.
  - q never leaves 0..MODULUS-1 by any input sequence.
  - When MODULUS == 2**WIDTH, the wrap result equals natural binary roll-over.
- Elaboration: MODULUS < 2 or MODULUS > 2**WIDTH is a configuration error; the block must flag it at elaboration, not silently truncate.

Test Plan:
1. Reset and up-wrap (defaults WIDTH=4, MODULUS=10): clr=0 pulse mid-cycle -> q=0, ovf=0 immediately. Then clr=1, en=1, up=1, sat=0 for 12 edges -> q = 1..9, 0, 1, 2. tc=1 only while q=9. ovf=1 from the edge where 9->0 onward.
2. Down-wrap and load clear: load=1, din=3 -> q=3, ovf=0. Then en=1, up=0, sat=0 for 5 edges -> q = 2, 1, 0, 9, 8. tc=1 while q=0. ovf set at the 0->9 edge.
3. Saturate: load din=8, then up=1, sat=1, en=1 for 3 edges -> q = 9, 9, 9 and ovf=1. Switch up=0, sat=1 from a load of din=1 -> q = 0, 0; ovf=1 after the second edge.
4. Priority and clamp:
   - load=1, en=1, din=15 -> q=9, ovf unchanged-to-0.
   - en=0 for 4 edges -> q holds 9 and tc=0.
   - Assert clr=0 with load=1 and en=1 -> q=0.
5. Cascade: two instances with MODULUS=10; stage0.tc drives stage1.en, both up=1, sat=0. After 25 edges from reset -> {stage1.q, stage0.q} = {2, 5}. After 100 edges -> {0, 0} and stage1.ovf=1.
6. Full binary modulus (WIDTH=3, MODULUS=8): 10 up edges from reset -> q = 1..7, 0, 1, 2, matching the legacy mod-8 sequence. Mid-count clr=0 returns q=0 asynchronously without waiting for clk.

Source files
------------

// File: rtl/modn_updown_counter.sv
// Parametrised modulo-MODULUS up/down counter with parallel load, wrap or
// saturate at the range ends, sticky overflow and a cascadable terminal count.

module modn_updown_counter_chk #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input logic             clk,
  input logic             clr,
  input logic             en,
  input logic             up,
  input logic             load,
  input logic [WIDTH-1:0] q,
  input logic             tc,
  input logic             ovf
);

  localparam logic [WIDTH-1:0] max_c  = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] zero_c = {WIDTH{1'b0}};

  a_q_in_range: assert property (@(posedge clk) disable iff (!clr) q <= max_c);

  a_tc_needs_en: assert property (@(posedge clk) disable iff (!clr) tc |-> en);

  a_tc_decode: assert property (@(posedge clk) disable iff (!clr)
    tc == (en & ((up & (q == max_c)) | (~up & (q == zero_c)))));

  a_load_clears_ovf: assert property (@(posedge clk) disable iff (!clr) load |=> !ovf);

endmodule

module modn_updown_counter #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             sat,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] max_c  = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] zero_c = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] one_c  = WIDTH'(1);

  // A modulus the count register cannot hold must stop elaboration, not truncate.
  generate
    if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
      $error("modn_updown_counter: MODULUS=%0d invalid for WIDTH=%0d", MODULUS, WIDTH);
    end
  endgenerate

  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] q_nxt_s;
  logic             ovf_r;
  logic             ovf_nxt_s;
  logic             at_max_s;
  logic             at_min_s;
  logic             tc_s;

  // End-of-range decode of the registered count; tc has zero latency for cascading.
  always_comb begin
    at_max_s = (q_r == max_c);
    at_min_s = (q_r == zero_c);
    tc_s     = en & ((up & at_max_s) | (~up & at_min_s));
  end

  // Next-state selection: load beats count beats hold.
  always_comb begin
    q_nxt_s   = q_r;
    ovf_nxt_s = ovf_r;
    if (load) begin
      q_nxt_s   = (din > max_c) ? max_c : din;
      ovf_nxt_s = 1'b0;
    end else if (en) begin
      if (tc_s) begin
        // Range end reached: flag it, then either stick or jump to the far end.
        ovf_nxt_s = 1'b1;
        if (sat) begin
          q_nxt_s = q_r;
        end else begin
          q_nxt_s = up ? zero_c : max_c;
        end
      end else begin
        ovf_nxt_s = ovf_r;
        q_nxt_s   = up ? (q_r + one_c) : (q_r - one_c);
      end
    end else begin
      q_nxt_s   = q_r;
      ovf_nxt_s = ovf_r;
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      q_r   <= zero_c;
      ovf_r <= 1'b0;
    end else begin
      q_r   <= q_nxt_s;
      ovf_r <= ovf_nxt_s;
    end
  end

  assign q   = q_r;
  assign ovf = ovf_r;
  assign tc  = tc_s;

  modn_updown_counter_chk #(
    .WIDTH   (WIDTH),
    .MODULUS (MODULUS)
  ) u_chk (
    .clk  (clk),
    .clr  (clr),
    .en   (en),
    .up   (up),
    .load (load),
    .q    (q_r),
    .tc   (tc_s),
    .ovf  (ovf_r)
  );

endmodule

// File: tb/tb_modn_updown_counter.sv
// Randomised and directed bench for modn_updown_counter: a decimal instance, a
// full-binary mod-8 instance and a two-digit decimal cascade against a reference model.
module tb_modn_updown_counter;

  logic clk;
  logic clr_a, en_a, up_a, load_a, sat_a, tc_a, ovf_a;
  logic [3:0] din_a, q_a;
  logic clr_b, en_b, up_b, load_b, sat_b, tc_b, ovf_b;
  logic [2:0] din_b, q_b;
  logic en_c, tc_c0, tc_c1, ovf_c0, ovf_c1;
  logic [3:0] q_c0, q_c1;

  int n_vec = 0;
  int n_err = 0;

  // reference model: index 0 = mod-10 instance, index 1 = mod-8 instance
  int mq[2];
  bit mo[2];
  int mm[2];
  int ncas;

  modn_updown_counter #(.WIDTH(4), .MODULUS(10)) dut_a (
    .clk(clk), .clr(clr_a), .en(en_a), .up(up_a), .load(load_a), .din(din_a),
    .sat(sat_a), .q(q_a), .tc(tc_a), .ovf(ovf_a));

  modn_updown_counter #(.WIDTH(3), .MODULUS(8)) dut_b (
    .clk(clk), .clr(clr_b), .en(en_b), .up(up_b), .load(load_b), .din(din_b),
    .sat(sat_b), .q(q_b), .tc(tc_b), .ovf(ovf_b));

  modn_updown_counter #(.WIDTH(4), .MODULUS(10)) dut_c0 (
    .clk(clk), .clr(clr_b), .en(en_c), .up(1'b1), .load(1'b0), .din(4'd0),
    .sat(1'b0), .q(q_c0), .tc(tc_c0), .ovf(ovf_c0));

  modn_updown_counter #(.WIDTH(4), .MODULUS(10)) dut_c1 (
    .clk(clk), .clr(clr_b), .en(tc_c0), .up(1'b1), .load(1'b0), .din(4'd0),
    .sat(1'b0), .q(q_c1), .tc(tc_c1), .ovf(ovf_c1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock edge of the counter rules, in plain integer arithmetic.
  task automatic model_edge(input int k, input bit c, input bit ld, input bit e,
                            input bit u, input bit s, input int d);
    int nxt;
    if (!c) begin
      mq[k] = 0;
      mo[k] = 1'b0;
    end else if (ld) begin
      mq[k] = (d < mm[k]) ? d : mm[k] - 1;
      mo[k] = 1'b0;
    end else if (e) begin
      nxt = u ? mq[k] + 1 : mq[k] - 1;
      if (nxt < 0 || nxt >= mm[k]) begin
        mo[k] = 1'b1;
        if (!s) mq[k] = (nxt + mm[k]) % mm[k];
      end else begin
        mq[k] = nxt;
      end
    end
  endtask

  function automatic int exp_tc(input int k, input bit e, input bit u);
    return (e && (u ? (mq[k] == mm[k] - 1) : (mq[k] == 0))) ? 1 : 0;
  endfunction

  // Check tc before the edge, apply the edge to the model, check registers after.
  task automatic cycle();
    #1;
    check_eq("tc_a", tc_a, exp_tc(0, en_a, up_a));
    check_eq("tc_b", tc_b, exp_tc(1, en_b, up_b));
    check_eq("tc_c0", tc_c0, (en_c && ncas % 10 == 9) ? 1 : 0);
    check_eq("tc_c1", tc_c1, (en_c && ncas % 100 == 99) ? 1 : 0);
    @(posedge clk);
    model_edge(0, clr_a, load_a, en_a, up_a, sat_a, int'(din_a));
    model_edge(1, clr_b, load_b, en_b, up_b, sat_b, int'(din_b));
    if (!clr_b) ncas = 0;
    else if (en_c) ncas++;
    #1;
    check_eq("q_a", q_a, mq[0]);
    check_eq("ovf_a", ovf_a, mo[0]);
    check_eq("q_b", q_b, mq[1]);
    check_eq("ovf_b", ovf_b, mo[1]);
    check_eq("q_c0", q_c0, ncas % 10);
    check_eq("q_c1", q_c1, (ncas / 10) % 10);
    check_eq("ovf_c0", ovf_c0, (ncas >= 10) ? 1 : 0);
    check_eq("ovf_c1", ovf_c1, (ncas >= 100) ? 1 : 0);
  endtask

  // Mid-cycle clear: outputs must drop with no clock edge.
  task automatic drop_clr_a();
    clr_a = 1'b0;
    #1;
    mq[0] = 0;
    mo[0] = 1'b0;
    check_eq("async_clr_q_a", q_a, 0);
    check_eq("async_clr_ovf_a", ovf_a, 0);
  endtask

  task automatic drop_clr_b();
    clr_b = 1'b0;
    #1;
    mq[1] = 0;
    mo[1] = 1'b0;
    ncas  = 0;
    check_eq("async_clr_q_b", q_b, 0);
    check_eq("async_clr_ovf_b", ovf_b, 0);
    check_eq("async_clr_q_c0", q_c0, 0);
    check_eq("async_clr_q_c1", q_c1, 0);
  endtask

  initial begin
    mm[0] = 10; mm[1] = 8;
    mq[0] = 0;  mq[1] = 0;
    mo[0] = 1'b0; mo[1] = 1'b0;
    ncas  = 0;
    clr_a = 1'b0; en_a = 1'b0; up_a = 1'b1; load_a = 1'b0; sat_a = 1'b0; din_a = 4'd0;
    clr_b = 1'b0; en_b = 1'b0; up_b = 1'b1; load_b = 1'b0; sat_b = 1'b0; din_b = 3'd0;
    en_c  = 1'b0;
    #2;
    check_eq("reset_q_a", q_a, 0);
    check_eq("reset_ovf_a", ovf_a, 0);
    check_eq("reset_q_b", q_b, 0);
    cycle();

    // up-count with wrap, interrupted by an asynchronous clear
    clr_a = 1'b1; en_a = 1'b1; up_a = 1'b1; sat_a = 1'b0;
    repeat (3) cycle();
    drop_clr_a();
    clr_a = 1'b1;
    repeat (12) cycle();
    check_eq("upwrap_q", q_a, 2);
    check_eq("upwrap_ovf", ovf_a, 1);

    // load clears ovf, then down-count with wrap
    load_a = 1'b1; din_a = 4'd3;
    cycle();
    check_eq("load3_q", q_a, 3);
    check_eq("load3_ovf", ovf_a, 0);
    load_a = 1'b0; up_a = 1'b0;
    repeat (5) cycle();
    check_eq("downwrap_q", q_a, 8);
    check_eq("downwrap_ovf", ovf_a, 1);

    // saturation at both ends
    load_a = 1'b1; din_a = 4'd8;
    cycle();
    load_a = 1'b0; up_a = 1'b1; sat_a = 1'b1;
    repeat (3) cycle();
    check_eq("sat_top_q", q_a, 9);
    check_eq("sat_top_ovf", ovf_a, 1);
    load_a = 1'b1; din_a = 4'd1;
    cycle();
    load_a = 1'b0; up_a = 1'b0;
    cycle();
    check_eq("sat_bot_q1", q_a, 0);
    check_eq("sat_bot_ovf1", ovf_a, 0);
    cycle();
    check_eq("sat_bot_q2", q_a, 0);
    check_eq("sat_bot_ovf2", ovf_a, 1);

    // load priority, clamp, hold, and clear overriding load
    load_a = 1'b1; en_a = 1'b1; din_a = 4'd15;
    cycle();
    check_eq("clamp_q", q_a, 9);
    check_eq("clamp_ovf", ovf_a, 0);
    load_a = 1'b0; en_a = 1'b0; up_a = 1'b1;
    repeat (4) cycle();
    check_eq("hold_q", q_a, 9);
    check_eq("hold_tc", tc_a, 0);
    load_a = 1'b1; en_a = 1'b1;
    drop_clr_a();
    cycle();
    check_eq("clr_over_load_q", q_a, 0);
    clr_a = 1'b1; load_a = 1'b0; en_a = 1'b0;

    // two-digit cascade and full-binary mod-8 from reset
    clr_b = 1'b1; en_b = 1'b1; up_b = 1'b1; sat_b = 1'b0; en_c = 1'b1;
    for (int n = 1; n <= 100; n++) begin
      cycle();
      if (n == 10) check_eq("mod8_after10", q_b, 2);
      if (n == 25) begin
        check_eq("cascade25_hi", q_c1, 2);
        check_eq("cascade25_lo", q_c0, 5);
      end
      if (n == 100) begin
        check_eq("cascade100_hi", q_c1, 0);
        check_eq("cascade100_lo", q_c0, 0);
        check_eq("cascade100_ovf", ovf_c1, 1);
      end
    end
    repeat (3) cycle();
    drop_clr_b();
    clr_b = 1'b1;

    // randomised traffic on every input, with occasional mid-cycle clears
    repeat (800) begin
      if (!clr_a) clr_a = 1'b1;
      else if ($urandom_range(49, 0) == 0) drop_clr_a();
      if (!clr_b) clr_b = 1'b1;
      else if ($urandom_range(79, 0) == 0) drop_clr_b();
      load_a = ($urandom_range(9, 0) == 0);
      en_a   = ($urandom_range(3, 0) != 0);
      up_a   = $urandom_range(1, 0) == 1;
      sat_a  = $urandom_range(1, 0) == 1;
      din_a  = 4'($urandom_range(15, 0));
      load_b = ($urandom_range(9, 0) == 0);
      en_b   = ($urandom_range(3, 0) != 0);
      up_b   = $urandom_range(1, 0) == 1;
      sat_b  = $urandom_range(1, 0) == 1;
      din_b  = 3'($urandom_range(7, 0));
      en_c   = ($urandom_range(3, 0) != 0);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
